dro_bank: RTL and testbench
===========================

Name: dro_bank

Overview:
- Parametrised, clocked, multi-channel successor to the single destructive-readout (DRO) cell.
- Each channel stores up to 2^CNT_W-1 flux quanta from rising edges on its set input.
- Each rising edge on the channel's reset (readout) input emits a one-cycle out pulse when the channel is non-empty.
- A runtime mode selects destructive (DRO) or non-destructive (NDRO) readout.
- Sticky overflow and set/reset collision flags serve the VCD-assertion benches and system-level SFQ logic models.

Parameters:
- CHANNELS, 4, number of independent storage channels (>=1).
- CNT_W, 2, per-channel quantum counter width; capacity MAX = 2^CNT_W-1 (CNT_W>=1; CNT_W=1 reproduces the single-quantum DRO).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set  input  CHANNELS  per-channel set level; a rising edge stores one quantum.
- reset  input  CHANNELS  per-channel readout level; a rising edge reads the channel.
- ndro  input  1  0 = destructive readout, 1 = non-destructive; sampled every cycle.
- clr_flags  input  1  synchronous clear of all sticky flags.
- out  output  CHANNELS  registered one-cycle readout pulse.
- count  output  CHANNELS*CNT_W  stored quanta; channel i occupies bits [i*CNT_W +: CNT_W].
- ovf  output  CHANNELS  sticky: a set arrived while the channel was full.
- coll  output  CHANNELS  sticky: set and reset events occurred in the same cycle.

Behaviour:
- Inputs are synchronous to clk; no internal synchroniser.
- Per channel, registers set_q and reset_q hold the previous sample.
  - set_evt = set & ~set_q.
  - rd_evt = reset & ~reset_q.
- Reset (rst_n=0, asynchronous):
  - count=0, out=0, ovf=0, coll=0.
  - set_q=1 and reset_q=1, so levels already high at reset release generate no event; a fresh 0->1 transition is required.
- Latency: the edge that first samples a rising input level also updates count and out, so results are visible after that edge (1 cycle).
- out is high for exactly one cycle per qualifying rd_evt, even if the input stays high.
- Per-channel update, in priority order:
  - set_evt & rd_evt:
    - out=1 (the quantum passes straight through).
    - count unchanged.
    - coll<=1.
  - set_evt only:
    - count<MAX: count+1.
    - count==MAX: count stays MAX, ovf<=1, out=0.
  - rd_evt only:
    - count==0: out=0, no state change.
    - count>0: out=1. If ndro=0, count-1. If ndro=1, count unchanged.
  - No event: out=0, count held.
- Flags:
  - clr_flags=1 clears ovf and coll at the clock edge.
  - A flag-setting event in the same cycle wins (flag ends at 1).
- Channels are fully independent; there is no cross-channel arbitration.
- Toggling ndro mid-stream takes effect on the next rd_evt; stored count is unaffected.
- Asynchronous reset mid-operation discards all stored quanta immediately; out drops in the same delta and does not wait for a clock edge.
- Count arithmetic is unsigned CNT_W bits, saturating at both ends, never wrapping.

Decomposition:
- Package dro_bank_pkg:
  - localparam function cnt_max(CNT_W).
  - typedef enum {MODE_DRO=0, MODE_NDRO=1} dro_mode_t.
  - Flag bit-index constants shared with the benches.
- Sub-module dro_cell:
  - One channel: edge detectors, saturating counter, out register, ovf/coll flags.
  - Parameter CNT_W.
- dro_bank instantiates CHANNELS copies of dro_cell in a generate loop and packs count.

Test Plan:
1. CHANNELS=4, CNT_W=2, ndro=0. Set ch0 rising twice, then reset ch0 rising three times -> count[0] goes 1,2,1,0,0; out[0] pulses on the first two readouts only; no flags.
2. ndro=1. Set ch1 once, then three readout edges on ch1 -> out[1] pulses three times; count[1] stays 1.
3. Four set edges on ch2 with MAX=3 -> count[2]=3 and ovf[2]=1 after the 4th. Then clr_flags=1 for one cycle -> ovf[2]=0, count[2] still 3.
4. set[3] and reset[3] rise in the same cycle with count[3]=0 -> out[3]=1 for one cycle, count[3]=0, coll[3]=1.
5. set[0]=1 held through rst_n release -> no event and count[0]=0. Then set low, then high -> count[0]=1.
6. Store count 2 on ch0 and 3 on ch2, pulse rst_n low between clock edges -> all outputs are 0 immediately. CNT_W=1 regression: set,set,reset -> ovf=1 and a single out pulse, matching the original DRO cell.

Source files
------------

// File: rtl/dro_bank_pkg.sv
// Shared types and constants for the multi-channel destructive-readout bank.
// The benches use the flag indices to decode the sticky-flag vector.
package dro_bank_pkg;

  typedef enum logic {
    MODE_DRO  = 1'b0,
    MODE_NDRO = 1'b1
  } dro_mode_t;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_COLL = 1;
  localparam int FLAG_W    = 2;

  // Largest quantum count a channel can hold for a given counter width.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/dro_cell.sv
// One storage channel: input edge detectors, saturating quantum counter,
// registered readout pulse and sticky overflow/collision flags.
module dro_cell
  import dro_bank_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             reset,
  input  logic             ndro,
  input  logic             clr_flags,
  output logic             out,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             coll
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic              set_q;
  logic              reset_q;
  logic              set_evt;
  logic              rd_evt;
  dro_mode_t         mode;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [CNT_W-1:0]  count_d;
  logic              out_d;

  assign set_evt = set & ~set_q;
  assign rd_evt  = reset & ~reset_q;
  assign mode    = dro_mode_t'(ndro);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    out_d   = 1'b0;
    count_d = count;
    flags_d = clr_flags ? '0 : flags_q;
    unique case ({set_evt, rd_evt})
      2'b11: begin
        // Incoming quantum passes straight through to the output.
        out_d              = 1'b1;
        flags_d[FLAG_COLL] = 1'b1;
      end
      2'b10: begin
        if (count != MAX) count_d = count + ONE;
        else              flags_d[FLAG_OVF] = 1'b1;
      end
      2'b01: begin
        if (count != '0) begin
          out_d = 1'b1;
          if (mode == MODE_DRO) count_d = count - ONE;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Levels already high at reset release must not count as edges.
      set_q   <= 1'b1;
      reset_q <= 1'b1;
      out     <= 1'b0;
      count   <= '0;
      flags_q <= '0;
    end else begin
      set_q   <= set;
      reset_q <= reset;
      out     <= out_d;
      count   <= count_d;
      flags_q <= flags_d;
    end
  end

  assign ovf  = flags_q[FLAG_OVF];
  assign coll = flags_q[FLAG_COLL];

endmodule

// File: rtl/dro_bank.sv
// Bank of independent DRO/NDRO storage channels sharing clock, reset,
// readout mode and flag clear; per-channel counts are packed into one bus.
module dro_bank
  import dro_bank_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       set,
  input  logic [CHANNELS-1:0]       reset,
  input  logic                      ndro,
  input  logic                      clr_flags,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       coll
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dro_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (set[i]),
      .reset    (reset[i]),
      .ndro     (ndro),
      .clr_flags(clr_flags),
      .out      (out[i]),
      .count    (count[i*CNT_W +: CNT_W]),
      .ovf      (ovf[i]),
      .coll     (coll[i])
    );
  end

endmodule

// File: tb/tb_dro_bank.sv
// Directed bench for dro_bank: a 4x2-bit bank driven from a vector table plus
// hand sequences for reset corners, and a 1x1-bit bank for the legacy DRO cell.
module tb_dro_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] set, rd;
  logic       ndro, clr;
  logic [3:0] out, ovf, coll;
  logic [7:0] count;

  logic       set1, rd1;
  logic       out1, ovf1, coll1;
  logic [0:0] count1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dro_bank #(.CHANNELS(4), .CNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .set(set), .reset(rd), .ndro(ndro),
    .clr_flags(clr), .out(out), .count(count), .ovf(ovf), .coll(coll)
  );

  dro_bank #(.CHANNELS(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .set(set1), .reset(rd1), .ndro(1'b0),
    .clr_flags(1'b0), .out(out1), .count(count1), .ovf(ovf1), .coll(coll1)
  );

  typedef struct {
    logic [3:0] s;
    logic [3:0] r;
    logic       n;
    logic       c;
    logic [3:0] o;
    logic [7:0] cnt;
    logic [3:0] ov;
    logic [3:0] co;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] s, input logic [3:0] r, input logic n,
                     input logic c, input logic [3:0] o, input logic [7:0] cnt,
                     input logic [3:0] ov, input logic [3:0] co);
    vec_t v;
    v.s = s; v.r = r; v.n = n; v.c = c;
    v.o = o; v.cnt = cnt; v.ov = ov; v.co = co;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set = '0; rd = '0; ndro = 1'b0; clr = 1'b0;
    set1 = 1'b0; rd1 = 1'b0;

    //    set     rd      n     c     out     count  ovf     coll
    // ch0 DRO: two sets, three readouts (last on empty)
    add(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h02, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h02, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 8'h01, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h01, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 8'h00, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    // ch1 NDRO: one set, three readouts keep count at 1
    add(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h04, 4'b0000, 4'b0000);
    // ch2: fill to MAX, overflow, then clear flags
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h14, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h14, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h24, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h24, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0100, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0100, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'h34, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0000, 4'b0000);
    // ch3: simultaneous set/readout on empty channel
    add(4'b1000, 4'b1000, 1'b0, 1'b0, 4'b1000, 8'h34, 4'b0000, 4'b1000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0000, 4'b1000);
    // clear and a new overflow in the same cycle: the overflow wins
    add(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'h34, 4'b0100, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h34, 4'b0100, 4'b0000);
    // ch1 back in DRO mode: the stored quantum is consumed
    add(4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0010, 8'h30, 4'b0100, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h30, 4'b0100, 4'b0000);
    // independent channels acting in the same cycle
    add(4'b0001, 4'b0100, 1'b0, 1'b0, 4'b0100, 8'h21, 4'b0100, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h21, 4'b0100, 4'b0000);

    // Reset state, checked while reset is asserted and after release.
    step();
    check("rst out", out, 4'b0000);
    check("rst count", count, 8'h00);
    check("rst flags", {ovf, coll}, 8'h00);
    check("rst dro1", {out1, count1, ovf1, coll1}, 4'b0000);
    rst_n = 1'b1;
    step();
    check("idle count", count, 8'h00);
    check("idle out", out, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      set = vecs[i].s; rd = vecs[i].r; ndro = vecs[i].n; clr = vecs[i].c;
      step();
      check($sformatf("v%0d out", i), out, vecs[i].o);
      check($sformatf("v%0d count", i), count, vecs[i].cnt);
      check($sformatf("v%0d ovf", i), ovf, vecs[i].ov);
      check($sformatf("v%0d coll", i), coll, vecs[i].co);
    end
    set = '0; rd = '0; ndro = 1'b0; clr = 1'b0;

    // Set held high through reset release produces no event.
    set = 4'b0001;
    step();
    rst_n = 1'b0;
    #1;
    check("hold rst count", count, 8'h00);
    check("hold rst flags", {ovf, coll}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    check("held set no evt", count, 8'h00);
    set = 4'b0000;
    step();
    check("held set low", count, 8'h00);
    set = 4'b0001;
    step();
    check("fresh edge", count, 8'h01);

    // Fill ch0=2, ch2=3, read ch0 non-destructively, then async reset.
    set = 4'b0000; step();
    set = 4'b0001; step();
    set = 4'b0000; step();
    check("ch0 two", count, 8'h02);
    set = 4'b0100; step();
    set = 4'b0000; step();
    set = 4'b0100; step();
    set = 4'b0000; step();
    set = 4'b0100; rd = 4'b0001; ndro = 1'b1;
    step();
    check("pre-rst out", out, 4'b0001);
    check("pre-rst count", count, 8'h32);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out", out, 4'b0000);
    check("async count", count, 8'h00);
    check("async flags", {ovf, coll}, 8'h00);
    set = '0; rd = '0; ndro = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Single-quantum DRO: set, set (overflow), readout.
    set1 = 1'b1; step();
    check("dro1 set cnt", count1, 1'b1);
    check("dro1 set ovf", ovf1, 1'b0);
    set1 = 1'b0; step();
    set1 = 1'b1; step();
    check("dro1 ovf", ovf1, 1'b1);
    check("dro1 sat cnt", count1, 1'b1);
    check("dro1 no out", out1, 1'b0);
    set1 = 1'b0; rd1 = 1'b1; step();
    check("dro1 read out", out1, 1'b1);
    check("dro1 read cnt", count1, 1'b0);
    step();
    check("dro1 one pulse", out1, 1'b0);
    rd1 = 1'b0; step();
    rd1 = 1'b1; step();
    check("dro1 empty read", out1, 1'b0);
    check("dro1 ovf sticky", ovf1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
